ahb_out_arbiter_param: RTL and testbench



---
 rtl/ahb_out_arbiter_param.sv | 126 ++++++++++++
 tb/tb_ahb_out_arbiter_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_out_arbiter_param.sv
// Output-stage arbiter for one AHB matrix output: picks which of NUM_PORTS input stages drives the slave port.
// Latency: one accepted HCLK cycle from request to addr_in_port/no_port (all outputs registered).
// Backpressure: state advances only on cycles with HREADYM=1; lock and (ARB_BURST_HOLD_EN) fixed-burst beats hold the grant.
module ahb_out_arbiter_param #(
  parameter int NUM_PORTS = 4,   // 2..16
  parameter int PORT_W    = 2,   // NUM_PORTS <= 2**PORT_W
  parameter int ARB_MODE  = 0    // 0 = fixed priority (port 0 highest), 1 = round-robin
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_active
);

  localparam logic [1:0] TR_IDLE = 2'b00;

  logic [PORT_W-1:0]    last_grant;
  logic [NUM_PORTS-1:0] eff_req;
  logic [PORT_W-1:0]    grant;
  logic                 burst_hold;
  logic                 cur_active;

  // The currently granted port keeps requesting while its own transfer is live on the bus.
  assign cur_active = !no_port && HSELM && (HTRANSM != TR_IDLE);

  // Effective request vector: external requests plus the implicit request of the owner.
  always_comb begin
    eff_req = req_port;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cur_active && (addr_in_port == PORT_W'(i))) eff_req[i] = 1'b1;
    end
  end

  // Grant selection: lowest index in fixed mode, circular scan after last_grant in round-robin mode.
  always_comb begin
    grant = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (eff_req[i]) grant = PORT_W'(i);
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        int idx;
        idx = int'(last_grant) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        // Scanning downward means the nearest candidate after last_grant is written last and wins.
        if (eff_req[idx]) grant = PORT_W'(idx);
      end
    end
  end

`ifdef ARB_BURST_HOLD_EN
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [3:0] beat_cnt;
  logic       fixed_burst;

  // WRAP4/INCR4 and longer are fixed-length; SINGLE and INCR may be interrupted.
  assign fixed_burst = (HBURSTM[2:1] != 2'b00);

  // Keep the grant until the final SEQ beat of a fixed-length burst is on the bus.
  assign burst_hold = HSELM && (((HTRANSM == TR_NONSEQ) && fixed_burst) ||
                                ((HTRANSM == TR_SEQ)    && (beat_cnt >= 4'd2)) ||
                                ((HTRANSM == TR_BUSY)   && (beat_cnt != 4'd0)));
  assign burst_active = (beat_cnt != 4'd0);

  // Beat counter: remaining SEQ beats of the current fixed-length burst.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      beat_cnt <= 4'd0;
    end else if (HREADYM) begin
      if (!HSELM) begin
        beat_cnt <= 4'd0;
      end else begin
        case (HTRANSM)
          TR_NONSEQ: begin
            case (HBURSTM)
              3'b010, 3'b011: beat_cnt <= 4'd3;
              3'b100, 3'b101: beat_cnt <= 4'd7;
              3'b110, 3'b111: beat_cnt <= 4'd15;
              default:        beat_cnt <= 4'd0;
            endcase
          end
          TR_SEQ:  if (beat_cnt != 4'd0) beat_cnt <= beat_cnt - 4'd1;
          TR_BUSY: beat_cnt <= beat_cnt;
          default: beat_cnt <= 4'd0;
        endcase
      end
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^HBURSTM;
  assign burst_hold   = 1'b0;
  assign burst_active = 1'b0;
`endif

  // Grant registers: lock and burst hold freeze the grant, otherwise re-arbitrate.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      last_grant   <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      if (!HMASTLOCKM && !burst_hold) begin
        if (|eff_req) begin
          addr_in_port <= grant;
          no_port      <= 1'b0;
          last_grant   <= grant;
        end else begin
          no_port      <= !HSELM;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_out_arbiter_param.sv
// Bench for ahb_out_arbiter_param: fixed-priority and round-robin instances share one stimulus stream.
// Expected outputs come from a queue filled by a behavioural model at stimulus time.
// A monitor pops one entry per clock and compares it with both instances.
module tb_ahb_out_arbiter_param;

  localparam int NP = 4;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] req;
  logic          rdy;
  logic          sel;
  logic [1:0]    trans;
  logic [2:0]    burst;
  logic          lock;

  logic [1:0] addr0, addr1;
  logic       nop0, nop1, ba0, ba1;

  ahb_out_arbiter_param #(.NUM_PORTS(NP), .PORT_W(2), .ARB_MODE(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
    .addr_in_port(addr0), .no_port(nop0), .burst_active(ba0));

  ahb_out_arbiter_param #(.NUM_PORTS(NP), .PORT_W(2), .ARB_MODE(1)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
    .addr_in_port(addr1), .no_port(nop1), .burst_active(ba1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a0;
    logic       n0;
    logic [1:0] a1;
    logic       n1;
    logic       ba;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   started     = 0;

  // Reference model state (index 0 = fixed priority, 1 = round-robin)
  int m_addr[2];
  bit m_nop[2];
  int m_last[2];
  int m_beat;

  function automatic int pick(int mode, logic [NP-1:0] eff, int last);
    if (mode == 0) begin
      for (int i = 0; i < NP; i++) if (eff[i]) return i;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int idx;
        idx = (last + k) % NP;
        if (eff[idx]) return idx;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input logic r_n, input logic [NP-1:0] r, input logic rd,
                            input logic s, input logic [1:0] tr, input logic [2:0] bu,
                            input logic lk);
    exp_t e;
    bit   hold;
    if (!r_n) begin
      for (int m = 0; m < 2; m++) begin
        m_addr[m] = 0;
        m_nop[m]  = 1;
        m_last[m] = NP - 1;
      end
      m_beat = 0;
    end else if (rd) begin
      hold = 0;
`ifdef ARB_BURST_HOLD_EN
      hold = s && ((tr == 2'b10 && bu >= 3'd2) ||
                   (tr == 2'b11 && m_beat >= 2) ||
                   (tr == 2'b01 && m_beat >= 1));
`endif
      for (int m = 0; m < 2; m++) begin
        if (!lk && !hold) begin
          logic [NP-1:0] eff;
          eff = r;
          if (s && tr != 2'b00 && !m_nop[m]) eff[m_addr[m]] = 1'b1;
          if (eff != 0) begin
            m_addr[m] = pick(m, eff, m_last[m]);
            m_last[m] = m_addr[m];
            m_nop[m]  = 0;
          end else begin
            m_nop[m] = !s;
          end
        end
      end
`ifdef ARB_BURST_HOLD_EN
      if (!s) m_beat = 0;
      else if (tr == 2'b10) m_beat = (bu >= 3'd6) ? 15 : (bu >= 3'd4) ? 7 : (bu >= 3'd2) ? 3 : 0;
      else if (tr == 2'b11) begin
        if (m_beat > 0) m_beat = m_beat - 1;
      end else if (tr == 2'b00) m_beat = 0;
`endif
    end
    e.a0 = 2'(m_addr[0]);
    e.n0 = m_nop[0];
    e.a1 = 2'(m_addr[1]);
    e.n1 = m_nop[1];
    e.ba = (m_beat != 0);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of bus inputs away from the sampling edge and record the expectation.
  task automatic drive(input logic r_n, input logic [NP-1:0] r, input logic rd, input logic s,
                       input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    @(negedge clk);
    rst_n = r_n; req = r; rdy = rd; sel = s; trans = tr; burst = bu; lock = lk;
    model_step(r_n, r, rd, s, tr, bu, lk);
    started = 1;
  endtask

  // Monitor: one expectation per rising edge, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (started) begin
          miscompares++;
          $display("FAIL underflow: monitor found no expectation at time %0t (required one per cycle)", $time);
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (addr0 !== e.a0 || nop0 !== e.n0 || addr1 !== e.a1 || nop1 !== e.n1 ||
            ba0 !== e.ba || ba1 !== e.ba) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t: actual fp(a=%0d n=%0b ba=%0b) rr(a=%0d n=%0b ba=%0b) required fp(a=%0d n=%0b) rr(a=%0d n=%0b) ba=%0b",
                   vectors, $time, addr0, nop0, ba0, addr1, nop1, ba1, e.a0, e.n0, e.a1, e.n1, e.ba);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; req = '0; rdy = 1; sel = 0; trans = 2'b00; burst = 3'b000; lock = 0;

    // Reset held with all requests pending, then release
    repeat (3) drive(0, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1010, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1000, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b0000, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b0000, 1, 1, 2'b00, 3'b000, 0);

    // Round-robin rotation with a stall cycle
    drive(0, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 0, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1111, 1, 0, 2'b00, 3'b000, 0);

    // Lock holds the grant, release re-arbitrates
    drive(1, 4'b0100, 1, 0, 2'b00, 3'b000, 0);
    repeat (3) drive(1, 4'b0001, 1, 1, 2'b10, 3'b000, 1);
    drive(1, 4'b0001, 1, 0, 2'b00, 3'b000, 0);

    // Owner keeps the port while its transfer is live
    drive(1, 4'b0010, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b0001, 1, 1, 2'b10, 3'b001, 0);
    drive(1, 4'b0001, 1, 1, 2'b00, 3'b000, 0);

    // Fixed-length burst from port 1 with competing requests
    drive(0, 4'b0000, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b0010, 1, 0, 2'b00, 3'b000, 0);
    drive(1, 4'b1101, 1, 1, 2'b10, 3'b011, 0);
    drive(1, 4'b1101, 1, 1, 2'b11, 3'b011, 0);
    drive(1, 4'b1101, 1, 1, 2'b01, 3'b011, 0);
    drive(1, 4'b1101, 1, 1, 2'b11, 3'b011, 0);
    drive(1, 4'b1101, 1, 1, 2'b11, 3'b011, 0);
    drive(1, 4'b1101, 1, 0, 2'b00, 3'b000, 0);

    // INCR8 terminated early by IDLE
    drive(1, 4'b0010, 1, 1, 2'b10, 3'b101, 0);
    drive(1, 4'b0010, 1, 1, 2'b11, 3'b101, 0);
    drive(1, 4'b0100, 1, 1, 2'b00, 3'b101, 0);
    drive(1, 4'b0000, 1, 0, 2'b00, 3'b000, 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic          r_n, rd, s, lk;
      logic [NP-1:0] r;
      logic [1:0]    tr;
      logic [2:0]    bu;
      r_n = ($urandom_range(0, 99) != 0);
      r   = NP'($urandom_range(0, (1 << NP) - 1));
      rd  = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 3) != 0);
      tr  = 2'($urandom_range(0, 3));
      bu  = 3'($urandom_range(0, 7));
      lk  = ($urandom_range(0, 9) == 0);
      drive(r_n, r, rd, s, tr, bu, lk);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
